// File: rtl/uart_msg_sender.sv
// rtl/uart_msg_sender.sv - buffered, triggered/periodic UART message sender (8N1; even parity when UART_PARITY_EN is defined)
module uart_msg_sender #(
    parameter int CLK_HZ    = 27_000_000,
    parameter int BAUD      = 115200,
    parameter int MSG_DEPTH = 16,
    parameter int PERIOD_MS = 1000,
    localparam int AW = $clog2(MSG_DEPTH),
    localparam int LW = $clog2(MSG_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          msg_we,
    input  logic [AW-1:0] msg_waddr,
    input  logic [7:0]    msg_wdata,
    input  logic [LW-1:0] msg_len,
    input  logic          trigger,
    input  logic          auto_en,
    output logic          busy,
    output logic          done,
    output logic          uart_tx
);
    localparam int BIT_CYC    = CLK_HZ / BAUD;
    localparam int PERIOD_CYC = (CLK_HZ / 1000) * PERIOD_MS;
    localparam int CW         = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int PW         = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYC - 1);
    localparam logic [LW-1:0] DEPTH_L  = LW'(MSG_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state, state_nx;
    logic [7:0]    mem [MSG_DEPTH];
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [AW-1:0] byte_idx, fetch_idx;
    logic [LW-1:0] len_q, len_clamp;
    logic [7:0]    cur_byte;
    logic [PW-1:0] per_cnt;
    logic          per_tick;
    logic          bit_end, last_byte, start_ok;
    logic          tx_d, done_d;

    assign len_clamp = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
    assign bit_end   = (bit_cnt == BIT_LAST);
    assign last_byte = ((LW'(byte_idx) + LW'(1)) == len_q);
    assign start_ok  = (state == S_IDLE) && (trigger || (per_tick && auto_en))
                       && (len_clamp != '0);
    // Each byte is read from the buffer as its start bit begins.
    assign fetch_idx  = (state == S_STOP) ? byte_idx + AW'(1) : '0;
    assign bit_idx_nx = (state == S_DATA && bit_end) ? bit_idx + 3'd1 : bit_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start_ok) state_nx = S_START;
            end
            S_START: begin
                if (bit_end) state_nx = S_DATA;
            end
            S_DATA: begin
                if (bit_end && (bit_idx == 3'd7)) begin
`ifdef UART_PARITY_EN
                    state_nx = S_PARITY;
`else
                    state_nx = S_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_nx = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) state_nx = last_byte ? S_IDLE : S_START;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Line level is computed for the upcoming state so uart_tx can be a plain flop.
    always_comb begin
        tx_d   = 1'b1;
        done_d = (state == S_STOP) && (state_nx == S_IDLE);
        busy   = (state != S_IDLE);
        case (state_nx)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = cur_byte[bit_idx_nx];
`ifdef UART_PARITY_EN
            S_PARITY: tx_d = ^cur_byte;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_tx  <= 1'b1;
            done     <= 1'b0;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            len_q    <= '0;
            cur_byte <= '0;
        end else begin
            uart_tx <= tx_d;
            done    <= done_d;
            bit_idx <= (state == S_IDLE) ? 3'd0 : bit_idx_nx;
            if (state == S_IDLE || bit_end) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + CW'(1);
            end
            if (state == S_IDLE) begin
                byte_idx <= '0;
            end else if (state == S_STOP && bit_end) begin
                byte_idx <= last_byte ? '0 : byte_idx + AW'(1);
            end
            if (start_ok) len_q <= len_clamp;
            if (state_nx == S_START && state != S_START) cur_byte <= mem[fetch_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_DEPTH; i++) mem[i] <= 8'h00;
        end else if (msg_we) begin
            mem[msg_waddr] <= msg_wdata;
        end
    end

    // Tick is registered, which puts one extra idle cycle between auto messages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt  <= '0;
            per_tick <= 1'b0;
        end else begin
            per_tick <= (state == S_IDLE) && auto_en && (per_cnt == PER_LAST);
            if (state == S_IDLE && auto_en) begin
                per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + PW'(1);
            end else begin
                per_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_msg_sender.sv
// tb/tb_uart_msg_sender.sv - randomized self-checking bench for uart_msg_sender against a line-level model
`timescale 1ns/1ps
module tb_uart_msg_sender;
    localparam int BITC  = 10;
    localparam int DEPTH = 8;
    localparam int PCYC  = 1000;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * BITC;

    logic       clk = 1'b0, rst_n = 1'b0, msg_we = 1'b0, trigger = 1'b0, auto_en = 1'b0;
    logic [2:0] msg_waddr = '0;
    logic [7:0] msg_wdata = '0;
    logic [3:0] msg_len = '0;
    logic       busy, done, uart_tx;

    uart_msg_sender #(
        .CLK_HZ(1_000_000), .BAUD(100_000), .MSG_DEPTH(DEPTH), .PERIOD_MS(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .msg_we(msg_we), .msg_waddr(msg_waddr),
        .msg_wdata(msg_wdata), .msg_len(msg_len), .trigger(trigger),
        .auto_en(auto_en), .busy(busy), .done(done), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0, cyc = 0;
    bit chk_en = 1'b0;

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound(string name, bit ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: wait expired, required event not seen", name);
        end
    endtask

    // Line model: message = len frames back to back, each frame start/8 data/[parity]/stop.
    logic [7:0] m_mem [DEPTH];
    logic [7:0] m_byte = '0;
    bit         m_busy = 1'b0, m_done = 1'b0;
    int         m_r = 0, m_len = 0, m_run = 0;

    function automatic logic m_line();
        int s;
        if (!m_busy) return 1'b1;
        s = (m_r % FRAME) / BITC;
        if (s == 0) return 1'b0;
        if (s <= 8) return m_byte[s-1];
        if (FB == 11 && s == 9) return ^m_byte;
        return 1'b1;
    endfunction

    always @(posedge clk) begin : model
        int  cl;
        bit  tick, start;
        cyc++;
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_r = 0; m_len = 0; m_run = 0; m_byte = '0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        end else begin
            cl = (int'(msg_len) > DEPTH) ? DEPTH : int'(msg_len);
            m_done = 1'b0;
            if (!m_busy) begin
                tick  = (m_run > 0) && (m_run % PCYC == 0);
                start = (trigger || (tick && auto_en)) && (cl != 0);
                m_run = auto_en ? m_run + 1 : 0;
                if (start) begin
                    m_busy = 1'b1; m_r = 0; m_len = cl; m_byte = m_mem[0];
                end
            end else begin
                m_run = 0;
                m_r++;
                if (m_r == m_len * FRAME) begin
                    m_busy = 1'b0; m_done = 1'b1;
                end else if (m_r % FRAME == 0) begin
                    m_byte = m_mem[m_r / FRAME];
                end
            end
            if (msg_we) m_mem[msg_waddr] = msg_wdata;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            n_cmp++;
            if (uart_tx !== m_line() || busy !== m_busy || done !== m_done) begin
                n_err++;
                $display("FAIL cycle %0d tx/busy/done: got %b%b%b, required %b%b%b",
                         cyc, uart_tx, busy, done, m_line(), m_busy, m_done);
            end
        end
    end

    // Independent mid-bit line receiver.
    logic [7:0] rx_q [$];
    bit         rx_par [$];
    int         rx_t [$];
    int         rst_epoch = 0;

    initial begin : rx
        logic [7:0] b;
        bit p;
        int ep, t;
        forever begin
            @(negedge clk);
            if (rst_n && uart_tx === 1'b0) begin
                ep = rst_epoch; t = cyc; p = 1'b0;
                repeat (BITC / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BITC) @(negedge clk);
                    b[i] = uart_tx;
                end
                if (FB == 11) begin
                    repeat (BITC) @(negedge clk);
                    p = uart_tx;
                end
                repeat (BITC) @(negedge clk);
                if (ep == rst_epoch) begin
                    rx_q.push_back(b); rx_par.push_back(p); rx_t.push_back(t);
                end
            end
        end
    end

    int busy_cnt = 0, done_cnt = 0;
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    function automatic int rxb(int i);
        if (i < rx_q.size()) return int'(rx_q[i]);
        return -1;
    endfunction

    function automatic int rxt(int i);
        if (i < rx_t.size()) return rx_t[i];
        return -100000;
    endfunction

    task automatic tick_n(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_byte(int a, logic [7:0] d);
        @(negedge clk);
        msg_we = 1'b1; msg_waddr = a[2:0]; msg_wdata = d;
        @(negedge clk);
        msg_we = 1'b0;
    endtask

    task automatic fire(output int tcyc);
        @(negedge clk);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        tcyc = cyc;
    endtask

    task automatic wait_done(string name, int limit, output int dcyc);
        int k = 0;
        while (done !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        bound(name, done === 1'b1);
        dcyc = cyc;
    endtask

    initial begin : wdog
        #800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] hi [4];
        int t, d, k;
        hi[0] = 8'h48; hi[1] = 8'h69; hi[2] = 8'h0D; hi[3] = 8'h0A;

        tick_n(3);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset uart_tx", uart_tx, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);

        // "Hi\r\n"
        for (int i = 0; i < 4; i++) write_byte(i, hi[i]);
        msg_len = 4'd4; rx_q.delete(); busy_cnt = 0; done_cnt = 0;
        fire(t);
        wait_done("t1 done", 5 * FRAME, d);
        tick_n(3);
        check("t1 done latency", d - t, 4 * FRAME);
        check("t1 busy cycles", busy_cnt, 4 * FRAME);
        check("t1 done pulses", done_cnt, 1);
        check("t1 byte count", rx_q.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("t1 byte%0d", i), rxb(i), int'(hi[i]));

        // auto repeat, with a trigger mid-frame that must be ignored
        write_byte(0, 8'h55);
        msg_len = 4'd1; rx_q.delete(); rx_t.delete();
        @(negedge clk); auto_en = 1'b1;
        k = 0;
        while (busy !== 1'b1 && k < 3 * PCYC) begin @(negedge clk); k++; end
        bound("t2 first auto start", busy === 1'b1);
        tick_n(FRAME / 2);
        trigger = 1'b1; @(negedge clk); trigger = 1'b0;
        k = 0;
        while (rx_t.size() < 3 && k < 4 * (FRAME + PCYC)) begin @(negedge clk); k++; end
        bound("t2 three auto messages", rx_t.size() >= 3);
        auto_en = 1'b0;
        k = 0;
        while (busy !== 1'b0 && k < 2 * FRAME) begin @(negedge clk); k++; end
        tick_n(20);
        check("t2 gap 0-1", rxt(1) - rxt(0), FRAME + PCYC + 1);
        check("t2 gap 1-2", rxt(2) - rxt(1), FRAME + PCYC + 1);
        check("t2 byte count", rx_q.size(), 3);
        check("t2 byte0", rxb(0), 8'h55);

        // zero length is ignored; oversize length clamps to the buffer depth
        msg_len = 4'd0; rx_q.delete(); busy_cnt = 0; done_cnt = 0;
        fire(t);
        tick_n(50);
        check("t3 len0 busy cycles", busy_cnt, 0);
        check("t3 len0 done pulses", done_cnt, 0);
        check("t3 len0 bytes", rx_q.size(), 0);
        for (int i = 0; i < DEPTH; i++) write_byte(i, 8'(8'h21 * (i + 1)));
        msg_len = 4'd12; busy_cnt = 0;
        fire(t);
        wait_done("t3 clamp done", 9 * FRAME, d);
        tick_n(3);
        check("t3 clamp bytes", rx_q.size(), DEPTH);
        check("t3 clamp busy", busy_cnt, DEPTH * FRAME);
        check("t3 clamp last", rxb(DEPTH - 1), 8'h08);

        // buffer write and msg_len change while busy
        write_byte(0, 8'h11); write_byte(1, 8'h22); write_byte(2, 8'h33); write_byte(3, 8'h44);
        msg_len = 4'd4; rx_q.delete();
        fire(t);
        tick_n(30);
        write_byte(3, 8'hA5);
        msg_len = 4'd1;
        wait_done("t4 done", 5 * FRAME, d);
        tick_n(3);
        check("t4 byte count", rx_q.size(), 4);
        check("t4 byte0", rxb(0), 8'h11);
        check("t4 byte3", rxb(3), 8'hA5);

        // asynchronous reset during data bits of byte 1
        write_byte(0, 8'h5A); write_byte(1, 8'h00);
        msg_len = 4'd2;
        fire(t);
        tick_n(FRAME + 30);
        #2;
        rst_n = 1'b0;
        rst_epoch++;
        #1;
        check("t5 async tx", uart_tx, 1);
        tick_n(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5 busy after reset", busy, 0);
        check("t5 done after reset", done, 0);
        tick_n(2 * FRAME);
        write_byte(0, 8'hC3); write_byte(1, 8'h3C);
        msg_len = 4'd2; rx_q.delete();
        fire(t);
        wait_done("t5 done", 3 * FRAME, d);
        tick_n(3);
        check("t5 byte count", rx_q.size(), 2);
        check("t5 byte0", rxb(0), 8'hC3);
        check("t5 byte1", rxb(1), 8'h3C);

`ifdef UART_PARITY_EN
        write_byte(0, 8'h07); write_byte(1, 8'h03);
        msg_len = 4'd2; rx_par.delete(); busy_cnt = 0;
        fire(t);
        wait_done("t6 done", 3 * FRAME, d);
        tick_n(3);
        check("t6 busy cycles", busy_cnt, 220);
        check("t6 parity 0x07", (rx_par.size() > 0) ? int'(rx_par[0]) : -1, 1);
        check("t6 parity 0x03", (rx_par.size() > 1) ? int'(rx_par[1]) : -1, 0);
`endif

        // randomized traffic: writes, length changes and triggers during busy, back-to-back starts
        for (int m = 0; m < 10; m++) begin
            int cnt;
            if (trigger !== 1'b1) begin
                for (int a = 0; a < DEPTH; a++)
                    if ($urandom_range(0, 1) == 1) write_byte(a, 8'($urandom));
                @(negedge clk);
                msg_len = 4'($urandom_range(1, 11));
                trigger = 1'b1;
            end
            cnt = 0;
            do begin
                @(negedge clk);
                trigger = 1'b0; msg_we = 1'b0; cnt++;
                if (done !== 1'b1) begin
                    if ($urandom_range(0, 9) == 0) begin
                        msg_we = 1'b1;
                        msg_waddr = 3'($urandom_range(0, 7));
                        msg_wdata = 8'($urandom);
                    end
                    if ($urandom_range(0, 19) == 0) trigger = 1'b1;
                    if ($urandom_range(0, 29) == 0) msg_len = 4'($urandom_range(0, 15));
                end
            end while (done !== 1'b1 && cnt < 12 * FRAME);
            bound($sformatf("rand msg %0d done", m), done === 1'b1);
            if (m < 9 && $urandom_range(0, 1) == 1) begin
                msg_len = 4'($urandom_range(1, 11));
                trigger = 1'b1;
            end
        end

        tick_n(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
